instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Upstream neighbour of the ALU stage.
- Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Registers each word and presents it, pre-split into R/I/J-type fields, to the ALU stage over a valid/ready handshake.
- Accepts a PC redirect from downstream for branches and jumps, discarding any wrong-path fetch.

Parameters:
WORD_SIZE, 32, width of PC and instruction-memory address
RESET_PC, 32'hBFC0_0000, PC value loaded at reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req  output  1  instruction-memory request
imem_addr  output  WORD_SIZE  fetch address, stable while imem_req=1 and imem_ack=0
imem_ack  input  1  one-cycle completion strobe; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  one-cycle PC redirect strobe
redirect_pc  input  WORD_SIZE  redirect target
dec_valid  output  1  decoded instruction available
dec_ready  input  1  ALU stage accepts
dec_pc  output  WORD_SIZE  PC of the presented instruction
opcode  output  6  instr[31:26]
rtype_rs, itype_rs  output  5  instr[25:21]
rtype_rt, itype_rt  output  5  instr[20:16]
rtype_rd  output  5  instr[15:11]
rtype_shamt  output  5  instr[10:6]
rtype_funct  output  6  instr[5:0]
itype_immediate  output  16  instr[15:0]
jtype_addres  output  26  instr[25:0]

Behaviour:
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - imem_req=0; dec_valid=0; dec_pc=0.
  - Instruction register=0, so all field outputs are 0.
  - imem_req drops immediately on rst_n assertion. Instruction memory tolerates an abandoned request.
- Field outputs are pure slices of the registered instruction word. They are stable whenever dec_valid=1 and change only on capture.
- States: IDLE, FETCH, ISSUE, DRAIN.
- IDLE:
  - Moves to FETCH one cycle after reset release.
  - A redirect here loads pc and then goes to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack without redirect:
    - instr<=imem_rdata; dec_pc<=pc; pc<=pc+PC_STEP (mod 2^WORD_SIZE, wraps to 0).
    - dec_valid<=1; go to ISSUE.
    - Latency: dec_valid rises on the cycle after imem_ack.
  - Redirect with imem_ack in the same cycle: rdata discarded; pc<=redirect_pc; stay in FETCH. The next cycle is a new request at the new address.
  - Redirect without imem_ack: pending<=redirect_pc; go to DRAIN.
- DRAIN:
  - imem_req held at 1 with the old address until imem_ack.
  - On imem_ack: rdata discarded; pc<=pending; go to FETCH.
  - Further redirects in DRAIN overwrite pending. The last redirect wins, including one coincident with imem_ack.
- ISSUE: dec_valid=1, imem_req=0.
  - dec_valid&dec_ready completes the transfer: dec_valid<=0; go to FETCH.
  - Redirect, with or without dec_ready: dec_valid<=0; pc<=redirect_pc; go to FETCH. If dec_ready was also high, the transfer counts as completed.
- Priority: reset > redirect > imem_ack > dec_ready.
- Throughput: one instruction per (memory latency + 2) cycles. No prefetch.
- Outputs never show X after reset. dec_pc is held while dec_valid=0.

Optional Feature:
- Macro IFETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_exc (1 bit, reset 0).
  - A redirect_pc with bits [1:0]≠0 sets fetch_exc, performs no fetch, and parks in IDLE until reset.
  - A later redirect is ignored while fetch_exc=1.
- Undefined: no fetch_exc port; redirect_pc[1:0] is forced to 2'b00.

Decomposition:
- Package mips_pkg holds:
  - instruction field bit positions
  - fetch state enum
  - opcode localparams shared with the ALU stage
- One natural sub-module, fetch_pc_ctrl: pc/pending registers, the state machine and the imem handshake.
- Field slicing and the output register stay in the top.

Test Plan:
- Reset release, imem acks 1 cycle after req with rdata=32'h2008_0005 → imem_addr=32'hBFC0_0000; dec_valid next cycle; opcode=6'h08, itype_rs=0, itype_rt=8, itype_immediate=16'h0005; dec_pc=32'hBFC0_0000; next req addr 32'hBFC0_0004.
- dec_ready held 0 for 5 cycles → dec_valid and all fields stable, imem_req=0; dec_ready=1 → next fetch at pc+4.
- Redirect to 32'h0000_0100 in FETCH 2 cycles before ack → req stays at old addr; acked data never appears on dec_valid; next req addr 32'h0000_0100.
- Redirect coincident with imem_ack, and two redirects during DRAIN (0x200 then 0x300) → no wrong-path issue; next fetch 0x300.
- pc=32'hFFFF_FFFC fetched → next imem_addr=0. Async reset asserted mid-FETCH → imem_req and dec_valid go to 0 without a clock edge.
- IFETCH_ALIGN_CHECK_EN defined, redirect_pc=32'h0000_0102 → fetch_exc=1, no further imem_req; undefined → fetch at 32'h0000_0100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction field positions, fetch FSM states
// and the opcode encodings the fetch/decode and ALU stages agree on.
package mips_pkg;

    localparam int unsigned InstrWidth = 32;

    // Field bit positions within a 32-bit instruction word
    localparam int unsigned OpcodeMsb  = 31;
    localparam int unsigned OpcodeLsb  = 26;
    localparam int unsigned RsMsb      = 25;
    localparam int unsigned RsLsb      = 21;
    localparam int unsigned RtMsb      = 20;
    localparam int unsigned RtLsb      = 16;
    localparam int unsigned RdMsb      = 15;
    localparam int unsigned RdLsb      = 11;
    localparam int unsigned ShamtMsb   = 10;
    localparam int unsigned ShamtLsb   = 6;
    localparam int unsigned FunctMsb   = 5;
    localparam int unsigned FunctLsb   = 0;
    localparam int unsigned ImmMsb     = 15;
    localparam int unsigned ImmLsb     = 0;
    localparam int unsigned JaddrMsb   = 25;
    localparam int unsigned JaddrLsb   = 0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StDrain
    } fetch_state_e;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnSlt   = 6'h2A;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// PC/pending registers, fetch state machine and instruction-memory handshake.
// Optional misaligned-redirect trap under IFETCH_ALIGN_CHECK_EN.
module fetch_pc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'hBFC0_0000,
    parameter int unsigned          PC_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 dec_valid,
    input  logic                 dec_ready,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic                 fetch_exc,
`endif
    output logic                 capture
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] pending_q, pending_d;
    logic                 req_q, req_d;
    logic                 valid_q, valid_d;
    logic                 redir;
    logic [WORD_SIZE-1:0] redir_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic exc_q, exc_d;
    logic misaligned;

    assign misaligned = redirect_valid && !exc_q && !is_word_aligned(redirect_pc[1:0]);
    assign redir      = redirect_valid && !exc_q && !misaligned;
    assign redir_pc   = redirect_pc;
    assign fetch_exc  = exc_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redir               = redirect_valid;
    assign redir_pc            = {redirect_pc[WORD_SIZE-1:2], 2'b00};
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        capture   = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        exc_d     = exc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (redir) begin
                    pc_d = redir_pc;
                end
                state_d = StFetch;
            end
            StFetch: begin
                if (redir) begin
                    if (imem_ack) begin
                        pc_d = redir_pc;
                    end else begin
                        // Outstanding request must complete before the new target is fetched
                        pending_d = redir_pc;
                        state_d   = StDrain;
                    end
                end else if (imem_ack) begin
                    capture = 1'b1;
                    pc_d    = pc_q + WORD_SIZE'(PC_STEP);
                    state_d = StIssue;
                end
            end
            StDrain: begin
                if (redir) begin
                    pending_d = redir_pc;
                end
                if (imem_ack) begin
                    pc_d    = redir ? redir_pc : pending_q;
                    state_d = StFetch;
                end
            end
            StIssue: begin
                if (redir) begin
                    pc_d    = redir_pc;
                    state_d = StFetch;
                end else if (dec_ready) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef IFETCH_ALIGN_CHECK_EN
        if (misaligned) begin
            exc_d = 1'b1;
        end
        if (misaligned || exc_q) begin
            state_d = StIdle;
            capture = 1'b0;
        end
`endif
        req_d   = (state_d == StFetch) || (state_d == StDrain);
        valid_d = (state_d == StIssue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            pending_q <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            exc_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            exc_q     <= exc_d;
`endif
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign dec_valid = valid_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: fetches words over req/ack and presents them,
// split into R/I/J fields, over valid/ready. IFETCH_ALIGN_CHECK_EN adds fetch_exc.
module instr_fetch_decode
    import mips_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'hBFC0_0000,
    parameter int unsigned          PC_STEP   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [WORD_SIZE-1:0]  imem_addr,
    input  logic                  imem_ack,
    input  logic [InstrWidth-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [WORD_SIZE-1:0]  redirect_pc,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [WORD_SIZE-1:0]  dec_pc,
    output logic [5:0]            opcode,
    output logic [4:0]            rtype_rs,
    output logic [4:0]            rtype_rt,
    output logic [4:0]            rtype_rd,
    output logic [4:0]            rtype_shamt,
    output logic [5:0]            rtype_funct,
    output logic [4:0]            itype_rs,
    output logic [4:0]            itype_rt,
    output logic [15:0]           itype_immediate,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic                  fetch_exc,
`endif
    output logic [25:0]           jtype_addres
);

    logic                  capture;
    logic [InstrWidth-1:0] instr_q, instr_d;
    logic [WORD_SIZE-1:0]  dec_pc_q, dec_pc_d;

    fetch_pc_ctrl #(
        .WORD_SIZE (WORD_SIZE),
        .RESET_PC  (RESET_PC),
        .PC_STEP   (PC_STEP)
    ) u_fetch_pc_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
`ifdef IFETCH_ALIGN_CHECK_EN
        .fetch_exc      (fetch_exc),
`endif
        .capture        (capture)
    );

    // imem_addr still holds the fetched PC in the capture cycle
    always_comb begin
        instr_d  = capture ? imem_rdata : instr_q;
        dec_pc_d = capture ? imem_addr : dec_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            dec_pc_q <= '0;
        end else begin
            instr_q  <= instr_d;
            dec_pc_q <= dec_pc_d;
        end
    end

    assign dec_pc          = dec_pc_q;
    assign opcode          = instr_q[OpcodeMsb:OpcodeLsb];
    assign rtype_rs        = instr_q[RsMsb:RsLsb];
    assign rtype_rt        = instr_q[RtMsb:RtLsb];
    assign rtype_rd        = instr_q[RdMsb:RdLsb];
    assign rtype_shamt     = instr_q[ShamtMsb:ShamtLsb];
    assign rtype_funct     = instr_q[FunctMsb:FunctLsb];
    assign itype_rs        = instr_q[RsMsb:RsLsb];
    assign itype_rt        = instr_q[RtMsb:RtLsb];
    assign itype_immediate = instr_q[ImmMsb:ImmLsb];
    assign jtype_addres    = instr_q[JaddrMsb:JaddrLsb];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a latency-programmable memory model
// and a scoreboard of right-path instructions.
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [5:0]  opcode;
    logic [4:0]  rtype_rs, rtype_rt, rtype_rd, rtype_shamt;
    logic [5:0]  rtype_funct;
    logic [4:0]  itype_rs, itype_rt;
    logic [15:0] itype_immediate;
    logic [25:0] jtype_addres;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fetch_exc;
`endif

    instr_fetch_decode dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .opcode          (opcode),
        .rtype_rs        (rtype_rs),
        .rtype_rt        (rtype_rt),
        .rtype_rd        (rtype_rd),
        .rtype_shamt     (rtype_shamt),
        .rtype_funct     (rtype_funct),
        .itype_rs        (itype_rs),
        .itype_rt        (itype_rt),
        .itype_immediate (itype_immediate),
`ifdef IFETCH_ALIGN_CHECK_EN
        .fetch_exc       (fetch_exc),
`endif
        .jtype_addres    (jtype_addres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 1;
    int          wait_cnt = 0;
    logic        draining = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [63:0] sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'hBFC0_0000) return 32'h2008_0005;
        return addr ^ 32'h3C1D_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive memory response for the coming edge, score the DUT, advance one cycle.
    task automatic step();
        logic [63:0] e;
        logic        req_s;
        if (prev_req && !prev_ack && imem_req) check("addr_stable", imem_addr, prev_addr);
        imem_ack   = imem_req && (wait_cnt == lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;
        if (imem_ack) begin
            if (redirect_valid || draining) draining = 1'b0;
            else sb.push_back({imem_addr, imem_rdata});
        end else if (imem_req && redirect_valid) begin
            draining = 1'b1;
        end
        if (dec_valid && redirect_valid) begin
            if (sb.size() > 0) e = sb.pop_front();
        end else if (dec_valid && dec_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_dec_pc", dec_pc, e[63:32]);
                check("sb_rtype", {opcode, rtype_rs, rtype_rt, rtype_rd, rtype_shamt,
                                   rtype_funct}, e[31:0]);
                check("sb_itype", {opcode, itype_rs, itype_rt, itype_immediate}, e[31:0]);
                check("sb_jtype", {opcode, jtype_addres}, e[31:0]);
            end
        end
        req_s     = imem_req;
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
        @(posedge clk);
        if (imem_ack) wait_cnt = 0;
        else if (req_s) wait_cnt++;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!imem_req && n < max) begin
            step();
            n++;
        end
        check("wait_req", 32'(imem_req), 32'd1);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!dec_valid && n < max) begin
            step();
            n++;
        end
        check("wait_valid", 32'(dec_valid), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_imm", 32'(itype_immediate), 32'h0);
        check("rst_jaddr", 32'(jtype_addres), 32'h0);
        check("rst_addr", imem_addr, 32'hBFC0_0000);
        rst_n = 1'b1;

        // First fetch, memory latency 1
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'hBFC0_0000);
        step();
        step();
        check("first_valid", 32'(dec_valid), 32'd1);
        check("first_opcode", 32'(opcode), 32'h08);
        check("first_rs", 32'(itype_rs), 32'd0);
        check("first_rt", 32'(itype_rt), 32'd8);
        check("first_imm", 32'(itype_immediate), 32'h0005);
        check("first_dec_pc", dec_pc, 32'hBFC0_0000);

        // Back-pressure: everything holds
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(dec_valid), 32'd1);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_opcode", 32'(opcode), 32'h08);
            check("hold_imm", 32'(itype_immediate), 32'h0005);
            check("hold_dec_pc", dec_pc, 32'hBFC0_0000);
        end
        dec_ready = 1'b1;
        lat       = 3;
        step();
        check("seq_req", 32'(imem_req), 32'd1);
        check("seq_addr", imem_addr, 32'hBFC0_0004);

        // Redirect two cycles before ack: old request drains, data discarded
        step();
        redirect(32'h0000_0100);
        step();
        check("drain_valid", 32'(dec_valid), 32'd0);
        check("drain_addr", imem_addr, 32'hBFC0_0004);
        step();
        step();
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_valid", 32'(dec_valid), 32'd0);
        wait_valid(20);
        check("redir_dec_pc", dec_pc, 32'h0000_0100);
        step();
        wait_req(5);
        check("after_redir_addr", imem_addr, 32'h0000_0104);

        // Redirect coincident with ack
        repeat (3) step();
        redirect(32'h0000_0180);
        step();
        check("coinc_addr", imem_addr, 32'h0000_0180);
        check("coinc_valid", 32'(dec_valid), 32'd0);

        // Three redirects during drain, last one on the ack cycle
        step();
        redirect(32'h0000_0200);
        step();
        redirect(32'h0000_0280);
        step();
        redirect(32'h0000_0300);
        step();
        check("multi_req", 32'(imem_req), 32'd1);
        check("multi_addr", imem_addr, 32'h0000_0300);
        check("multi_valid", 32'(dec_valid), 32'd0);
        wait_valid(20);
        check("multi_dec_pc", dec_pc, 32'h0000_0300);
        step();
        wait_req(5);
        check("multi_next", imem_addr, 32'h0000_0304);

        // PC wrap at the top of the address space
        lat = 1;
        redirect(32'hFFFF_FFFC);
        step();
        step();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(20);
        check("wrap_dec_pc", dec_pc, 32'hFFFF_FFFC);
        step();
        wait_req(5);
        check("wrap_next", imem_addr, 32'h0000_0000);

        // Misaligned redirect target
        lat = 0;
        redirect(32'h0000_0102);
        step();
`ifdef IFETCH_ALIGN_CHECK_EN
        check("align_exc", 32'(fetch_exc), 32'd1);
        check("align_req", 32'(imem_req), 32'd0);
        redirect(32'h0000_0200);
        repeat (4) step();
        check("align_parked", 32'(imem_req), 32'd0);
        check("align_exc_held", 32'(fetch_exc), 32'd1);
`else
        check("align_req", 32'(imem_req), 32'd1);
        check("align_addr", imem_addr, 32'h0000_0100);
        wait_valid(20);
        check("align_dec_pc", dec_pc, 32'h0000_0100);
        step();
        wait_req(5);
`endif
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a fetch
        lat = 5;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_valid", 32'(dec_valid), 32'd0);
        check("async_dec_pc", dec_pc, 32'h0);
        check("async_opcode", 32'(opcode), 32'h0);
        check("async_addr", imem_addr, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
